strhw_hash_ctrl: RTL and testbench
==================================

# strhw_hash_ctrl

Top-level sequencer for the Streebog (GOST 34.11-2018) hash core. It accepts 512-bit message blocks over a valid/ready handshake and drives an external compression engine g_N(h, m) through a start/done handshake. It maintains the chaining value h, the bit counter N and the checksum Sigma, pads the final block, and runs the two finalisation compressions. Supports both 512-bit and 256-bit digests.

## Interface
- No parameters.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin a new hash; sampled in any state.
- mode_256_i  in  1  digest size, sampled with start_i: 1 = 256-bit, 0 = 512-bit.
- blk_valid_i  in  1  block offered.
- blk_ready_o  out  1  block accepted when valid && ready.
- blk_data_i  in  512  message block. Valid bits are [k-1:0].
- blk_last_i  in  1  final block of the message.
- blk_bits_i  in  10  k, the number of valid bits. Used only when blk_last_i=1; values above 512 are clamped to 512.
- g_start_o  out  1  one-cycle pulse that launches the engine.
- g_h_o, g_n_o, g_m_o  out  512 each  engine operands h, N, m.
- g_done_i  in  1  one-cycle engine completion.
- g_result_i  in  512  new h; valid while g_done_i is high.
- state_o  out  state_t  CLEAR / BUSY / READY / DONE.
- digest_o  out  512  final hash.
- digest_valid_o  out  1  high while in DONE.

## Operation
- FSM states, with the state_o value for each:
  - IDLE (CLEAR)
  - WAIT_BLK (READY)
  - COMP_MSG (BUSY)
  - COMP_PAD (BUSY)
  - COMP_N (BUSY)
  - COMP_SIG (BUSY)
  - FIN (DONE)
- Transitions:
  - IDLE: start_i -> WAIT_BLK. h <= INIT_VECTOR_512 or INIT_VECTOR_256 according to mode; N <= 0; Sigma <= 0.
  - WAIT_BLK: on accept -> COMP_MSG. The block is latched into m (padded if last).
  - COMP_MSG on g_done_i:
    - not last -> WAIT_BLK;
    - last with k=512 -> COMP_PAD;
    - last with k<512 -> COMP_N.
  - COMP_PAD on g_done_i -> COMP_N. m = 512'h1, N increment 0.
  - COMP_N on g_done_i -> COMP_SIG. Operands are h, n=0, m=N.
  - COMP_SIG on g_done_i -> FIN. Operands are h, n=0, m=Sigma.
  - FIN: hold the digest until start_i or rst.
- Padding for the last block with k<512: m = (blk_data_i masked to bits [k-1:0]) | (1<<k). Bits above the marker are forced to 0 whatever blk_data_i holds there.
- Updates on g_done_i in COMP_MSG/COMP_PAD:
  - h <= g_result_i;
  - N <= N + (k, or 512 for non-last blocks) mod 2^512;
  - Sigma <= Sigma + m mod 2^512.
  - In COMP_N/COMP_SIG only h is updated.
- g_n_o = N in COMP_MSG/COMP_PAD and 0 in COMP_N/COMP_SIG.
- Digest: in 512 mode digest_o = h. In 256 mode digest_o = {256'b0, h[511:256]}.
- start_i in any state other than IDLE aborts the current hash and re-initialises as from IDLE. Any pending g_done_i from the aborted run is ignored; the engine must be idle or tolerate an abandoned run.
- g_done_i outside COMP_* states is ignored.

## Timing
- Reset values: state IDLE; blk_ready_o=0, g_start_o=0, digest_valid_o=0; digest_o, g_*_o, h, N and Sigma all 0.
- blk_ready_o is 1 exactly in WAIT_BLK. It is a registered output, with no combinational path from blk_valid_i.
- g_start_o pulses in the cycle after entry to each COMP_* state. An accept at cycle t gives g_start_o at t+2.
- g_h_o, g_n_o and g_m_o are stable from the g_start_o cycle until g_done_i.
- After g_done_i at cycle t, the next state is entered at t+1 and g_start_o is asserted at t+2.
- With an engine latency of L cycles (start to done), the overhead per block is L+3 cycles. From the last accept to digest_valid_o it is 3(L+2)+1 cycles, or 4(L+2)+1 when k=512.
- start_i takes precedence over a simultaneous accept or g_done_i.

## Structure
- Add to the shared package strhw_common_types: ctrl_state_t (the seven FSM states) and uint10 (the blk_bits type). state_t, uint512 and the IV constants already live there.
- One sub-module: strhw_pad, a combinational k-bit mask plus marker insertion. Its inputs are data and k; its output is the padded m.
- The N and Sigma adders stay inline as 512-bit adds.

## Test plan
- Empty message, 512 mode, using a stub engine (result = h^n^m, L=5). Send a single last block with k=0. Required operands:
  - m=512'h1 and n=0;
  - then m=0 (N) and n=0;
  - then m=1 (Sigma).
  - digest_o equals the model output.
- Blocks A (not last) then B (last, k=512), 512 mode. Required sequence:
  - compressions with n = 0, 512, 1024 (pad m=1);
  - COMP_N with m=1024;
  - COMP_SIG with m=A+B+1 mod 2^512;
  - exactly 5 g_start_o pulses in total.
- Last block with k=504 and all-ones data. Required: m has bits [503:0]=1, bit 504=1, bits [511:505]=0; N ends at 504.
- Backpressure: hold blk_valid_i while BUSY with L=37. Required: blk_ready_o=0 throughout, no second accept, and operands stable across all 37 cycles.
- Abort handling:
  - start_i mid-COMP_MSG: returns to WAIT_BLK with h=IV, N=0, Sigma=0, and the late g_done_i is ignored.
  - rst mid-COMP_N: every output returns to its reset value.
- 256 mode with blk_bits_i=700 on a last block. Required: k is clamped to 512 (pad block follows), and digest_o[511:256]=0 while digest_o[255:0]=h[511:256].

Source files
------------

// File: rtl/strhw_common_types.sv
// strhw_common_types: shared types and constants for the Streebog hash blocks
package strhw_common_types;
    typedef logic [511:0] uint512;
    typedef logic [9:0] uint10;
    typedef enum logic [1:0] {CLEAR, BUSY, READY, DONE} state_t;
    typedef enum logic [2:0] {IDLE, WAIT_BLK, COMP_MSG, COMP_PAD, COMP_N, COMP_SIG, FIN} ctrl_state_t;
    localparam uint512 INIT_VECTOR_512 = '0;
    localparam uint512 INIT_VECTOR_256 = {64{8'h01}};
    localparam uint10 BLK_BITS = 10'd512;
    function automatic state_t ext_state(ctrl_state_t s);
        return s == IDLE ? CLEAR : s == WAIT_BLK ? READY : s == FIN ? DONE : BUSY;
    endfunction
endpackage

// File: rtl/strhw_pad.sv
// strhw_pad: keep the low k message bits and set the marker bit at position k
module strhw_pad
    import strhw_common_types::*;
(
    input  logic [511:0] data_i,
    input  logic [9:0]   k_i,
    output logic [511:0] m_o
);
    uint512 mark;
    // k=512 shifts the marker out, so the mask becomes all ones and data passes through
    assign mark = uint512'(1) << k_i;
    assign m_o = (data_i & (mark - uint512'(1))) | mark;
endmodule

// File: rtl/strhw_hash_ctrl.sv
// strhw_hash_ctrl: Streebog block sequencer driving an external g_N compression engine
module strhw_hash_ctrl
    import strhw_common_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         mode_256_i,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [511:0] blk_data_i,
    input  logic         blk_last_i,
    input  logic [9:0]   blk_bits_i,
    output logic         g_start_o,
    output logic [511:0] g_h_o,
    output logic [511:0] g_n_o,
    output logic [511:0] g_m_o,
    input  logic         g_done_i,
    input  logic [511:0] g_result_i,
    output state_t       state_o,
    output logic [511:0] digest_o,
    output logic         digest_valid_o
);
    ctrl_state_t state_q, state_d;
    uint512 h_q, h_d, n_q, n_d, sig_q, sig_d, m_q, m_d, pad_m;
    uint10 inc_q, inc_d, k_eff;
    logic last_q, last_d, mode_q, mode_d, ent_q, ent_d;
    logic blk_ready_q, blk_ready_d, g_start_q, g_start_d;

    assign k_eff = !blk_last_i ? BLK_BITS : (blk_bits_i > BLK_BITS ? BLK_BITS : blk_bits_i);

    strhw_pad u_pad (.data_i(blk_data_i), .k_i(k_eff), .m_o(pad_m));

    always_comb begin
        state_d = state_q;
        h_d = h_q;
        n_d = n_q;
        sig_d = sig_q;
        m_d = m_q;
        inc_d = inc_q;
        last_d = last_q;
        mode_d = mode_q;
        ent_d = 1'b0;
        if (start_i) begin
            state_d = WAIT_BLK;
            mode_d = mode_256_i;
            h_d = mode_256_i ? INIT_VECTOR_256 : INIT_VECTOR_512;
            n_d = '0;
            sig_d = '0;
            m_d = '0;
            inc_d = '0;
            last_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_BLK: if (blk_valid_i && blk_ready_q) begin
                    state_d = COMP_MSG;
                    m_d = pad_m;
                    inc_d = k_eff;
                    last_d = blk_last_i;
                    ent_d = 1'b1;
                end
                COMP_MSG: if (g_done_i) begin
                    h_d = g_result_i;
                    n_d = n_q + uint512'(inc_q);
                    sig_d = sig_q + m_q;
                    state_d = !last_q ? WAIT_BLK : inc_q == BLK_BITS ? COMP_PAD : COMP_N;
                    m_d = inc_q == BLK_BITS ? uint512'(1) : n_d;
                    ent_d = last_q;
                end
                COMP_PAD: if (g_done_i) begin
                    h_d = g_result_i;
                    sig_d = sig_q + m_q;
                    m_d = n_q;
                    state_d = COMP_N;
                    ent_d = 1'b1;
                end
                COMP_N: if (g_done_i) begin
                    h_d = g_result_i;
                    m_d = sig_q;
                    state_d = COMP_SIG;
                    ent_d = 1'b1;
                end
                COMP_SIG: if (g_done_i) begin
                    h_d = g_result_i;
                    state_d = FIN;
                end
                default: ;
            endcase
        end
        blk_ready_d = state_d == WAIT_BLK;
        g_start_d = ent_q && !start_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_q <= '0;
            n_q <= '0;
            sig_q <= '0;
            m_q <= '0;
            inc_q <= '0;
            last_q <= 1'b0;
            mode_q <= 1'b0;
            ent_q <= 1'b0;
            blk_ready_q <= 1'b0;
            g_start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q <= h_d;
            n_q <= n_d;
            sig_q <= sig_d;
            m_q <= m_d;
            inc_q <= inc_d;
            last_q <= last_d;
            mode_q <= mode_d;
            ent_q <= ent_d;
            blk_ready_q <= blk_ready_d;
            g_start_q <= g_start_d;
        end
    end

    assign blk_ready_o = blk_ready_q;
    assign g_start_o = g_start_q;
    assign g_h_o = h_q;
    assign g_n_o = (state_q == COMP_MSG || state_q == COMP_PAD) ? n_q : '0;
    assign g_m_o = m_q;
    assign state_o = ext_state(state_q);
    assign digest_o = mode_q ? {256'b0, h_q[511:256]} : h_q;
    assign digest_valid_o = state_q == FIN;
endmodule

// File: tb/tb_strhw_hash_ctrl.sv
// tb_strhw_hash_ctrl: randomized scoreboard bench for strhw_hash_ctrl with a stub g_N engine (h^n^m)
module tb_strhw_hash_ctrl;
    import strhw_common_types::*;

    logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, mode_256_i = 1'b0;
    logic blk_valid_i = 1'b0, blk_last_i = 1'b0, g_done_i = 1'b0;
    uint512 blk_data_i = '0, g_result_i = '0;
    uint10 blk_bits_i = '0;
    logic blk_ready_o, g_start_o, digest_valid_o;
    uint512 g_h_o, g_n_o, g_m_o, digest_o;
    state_t state_o;

    int checks = 0, errors = 0, start_cnt = 0, accepts = 0, busy_rdy = 0, lat = 5;
    typedef struct {uint512 h; uint512 n; uint512 m;} op_t;
    op_t op_q[$];
    op_t mon_op;
    uint512 dig_q[$];
    uint512 mh, mn, ms, mon_dig;
    logic mmode = 1'b0, dv_prev = 1'b0;

    always #5 clk = ~clk;

    strhw_hash_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_256_i(mode_256_i),
        .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
        .blk_last_i(blk_last_i), .blk_bits_i(blk_bits_i), .g_start_o(g_start_o),
        .g_h_o(g_h_o), .g_n_o(g_n_o), .g_m_o(g_m_o), .g_done_i(g_done_i),
        .g_result_i(g_result_i), .state_o(state_o), .digest_o(digest_o),
        .digest_valid_o(digest_valid_o)
    );

    task automatic check(string name, uint512 act, uint512 exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic uint512 rand512();
        uint512 r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Reference model: message bits kept below k, marker at k, nothing above
    function automatic uint512 pad_ref(uint512 d, int k);
        uint512 r;
        for (int j = 0; j < 512; j++) r[j] = (j < k) ? d[j] : (j == k);
        return r;
    endfunction

    task automatic model_call(uint512 n, uint512 m);
        op_q.push_back('{mh, n, m});
        mh = mh ^ n ^ m;
    endtask

    task automatic model_blk(uint512 d, logic last, int bits);
        int k;
        uint512 m;
        k = !last ? 512 : (bits > 512 ? 512 : bits);
        m = pad_ref(d, k);
        model_call(mn, m);
        mn = mn + uint512'(k);
        ms = ms + m;
        if (last) begin
            if (k == 512) begin
                model_call(mn, uint512'(1));
                ms = ms + uint512'(1);
            end
            model_call('0, mn);
            model_call('0, ms);
            dig_q.push_back(mmode ? {256'b0, mh[511:256]} : mh);
        end
    endtask

    // Monitor: scoreboard pops on every engine launch and on digest arrival
    always @(negedge clk) begin
        if (g_start_o) begin
            start_cnt++;
            if (op_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL op_unexpected: g_start_o with no expected operation, m=%h", g_m_o);
            end else begin
                mon_op = op_q.pop_front();
                check("op_h", g_h_o, mon_op.h);
                check("op_n", g_n_o, mon_op.n);
                check("op_m", g_m_o, mon_op.m);
            end
        end
        if (digest_valid_o && !dv_prev) begin
            if (dig_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL digest_unexpected: digest_valid_o with digest %h", digest_o);
            end else begin
                mon_dig = dig_q.pop_front();
                check("digest", digest_o, mon_dig);
            end
        end
        if (state_o == BUSY && blk_ready_o) busy_rdy++;
        dv_prev = digest_valid_o;
    end

    always @(posedge clk) if (blk_valid_i && blk_ready_o) accepts++;

    // Stub engine: result = h^n^m after lat cycles, operands watched for stability
    initial begin
        uint512 eh, en, em;
        logic ab, st;
        int l;
        forever begin
            @(posedge clk);
            #1;
            if (g_start_o) begin
                eh = g_h_o;
                en = g_n_o;
                em = g_m_o;
                ab = 1'b0;
                st = 1'b1;
                l = lat;
                for (int i = 0; i < l; i++) begin
                    @(posedge clk);
                    #1;
                    ab = ab | rst | start_i;
                    if (!ab && {g_h_o, g_n_o, g_m_o} !== {eh, en, em}) st = 1'b0;
                end
                if (!ab) begin
                    checks++;
                    if (!st) begin
                        errors++;
                        $display("FAIL operand_stable: operands changed during run, got m=%h required m=%h", g_m_o, em);
                    end
                end
                g_result_i = eh ^ en ^ em;
                g_done_i = 1'b1;
                @(posedge clk);
                #1;
                g_done_i = 1'b0;
            end
        end
    end

    task automatic do_start(logic mode);
        @(negedge clk);
        start_i = 1'b1;
        mode_256_i = mode;
        mh = mode ? INIT_VECTOR_256 : INIT_VECTOR_512;
        mn = '0;
        ms = '0;
        mmode = mode;
        @(negedge clk);
        start_i = 1'b0;
        mode_256_i = 1'b0;
    endtask

    task automatic send_blk(uint512 d, logic last, int bits);
        int c = 0;
        model_blk(d, last, bits);
        @(negedge clk);
        blk_valid_i = 1'b1;
        blk_data_i = d;
        blk_last_i = last;
        blk_bits_i = uint10'(bits);
        while (!blk_ready_o && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (!blk_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready=%0d after %0d cycles, required 1", blk_ready_o, c);
        end
        @(negedge clk);
        blk_valid_i = 1'b0;
        blk_data_i = rand512();
        blk_last_i = 1'b0;
        blk_bits_i = uint10'($urandom_range(0, 1023));
    endtask

    task automatic wait_fin();
        int c = 0;
        while (!digest_valid_o && c < 5000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!digest_valid_o) begin
            errors++;
            $display("FAIL fin_timeout: digest_valid_o=%0d after %0d cycles, required 1", digest_valid_o, c);
        end
        @(negedge clk);
    endtask

    task automatic wait_starts(int n);
        int c = 0;
        while (start_cnt < n && c < 5000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (start_cnt < n) begin
            errors++;
            $display("FAIL start_timeout: %0d launches, required %0d", start_cnt, n);
        end
    endtask

    task automatic check_rst(string tag);
        check({tag, "_state"}, uint512'(state_o), uint512'(CLEAR));
        check({tag, "_ready"}, uint512'(blk_ready_o), '0);
        check({tag, "_gstart"}, uint512'(g_start_o), '0);
        check({tag, "_dvalid"}, uint512'(digest_valid_o), '0);
        check({tag, "_digest"}, digest_o, '0);
        check({tag, "_gh"}, g_h_o, '0);
        check({tag, "_gn"}, g_n_o, '0);
        check({tag, "_gm"}, g_m_o, '0);
    endtask

    task automatic run_msg(logic mode, int nblk, int bits, int l);
        int s;
        int k;
        lat = l;
        s = start_cnt;
        k = bits > 512 ? 512 : bits;
        do_start(mode);
        for (int i = 0; i < nblk; i++) send_blk(rand512(), i == nblk - 1, bits);
        wait_fin();
        check("msg_starts", uint512'(start_cnt - s), uint512'(nblk + 2 + (k == 512 ? 1 : 0)));
    endtask

    initial begin
        int s, b0, a0;
        repeat (3) @(negedge clk);
        check_rst("reset");
        rst = 1'b0;

        run_msg(1'b0, 1, 0, 5);
        run_msg(1'b0, 2, 512, 5);

        lat = 3;
        s = start_cnt;
        do_start(1'b0);
        send_blk('1, 1'b1, 504);
        wait_fin();
        check("k504_starts", uint512'(start_cnt - s), uint512'(3));

        lat = 37;
        b0 = busy_rdy;
        a0 = accepts;
        do_start(1'b0);
        send_blk(rand512(), 1'b0, 0);
        send_blk(rand512(), 1'b1, 300);
        wait_fin();
        check("ready_in_busy", uint512'(busy_rdy - b0), '0);
        check("accept_count", uint512'(accepts - a0), uint512'(2));

        lat = 20;
        do_start(1'b0);
        s = start_cnt;
        send_blk(rand512(), 1'b0, 0);
        wait_starts(s + 1);
        repeat (3) @(negedge clk);
        op_q.delete();
        do_start(1'b1);
        check("abort_state", uint512'(state_o), uint512'(READY));
        check("abort_ready", uint512'(blk_ready_o), uint512'(1));
        repeat (30) @(negedge clk);
        check("late_done_state", uint512'(state_o), uint512'(READY));
        send_blk(rand512(), 1'b1, 100);
        wait_fin();

        lat = 10;
        do_start(1'b0);
        s = start_cnt;
        send_blk(rand512(), 1'b1, 100);
        wait_starts(s + 2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_rst("abort_rst");
        rst = 1'b0;
        op_q.delete();
        dig_q.delete();
        repeat (15) @(negedge clk);
        check("rst_late_done", uint512'(state_o), uint512'(CLEAR));

        run_msg(1'b1, 1, 700, 4);
        check("d256_upper", uint512'(digest_o[511:256]), '0);
        check("d256_lower", uint512'(digest_o[255:0]), uint512'(mh[511:256]));

        for (int i = 0; i < 6; i++)
            run_msg(1'(($urandom() & 1)), $urandom_range(1, 3),
                    ($urandom_range(0, 3) == 0) ? 512 : $urandom_range(0, 700), $urandom_range(1, 8));

        check("queues_empty", uint512'(op_q.size() + dig_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
